// File: rtl/key_press_ctrl.sv
// key_press_ctrl
//   Turns a raw active-low push-button into debounced press events and
//   sequences a wrap-around mode counter. A short press advances the mode;
//   a long press returns it to mode 0.
//
// Ports
//   clk          in   system clock, rising edge
//   rstn         in   asynchronous active-low reset
//   key_in       in   raw key, asynchronous; 1 = released, 0 = pressed
//   pressed      out  debounced key state; 1 = pressed
//   short_pulse  out  one-cycle strobe for a short press
//   long_pulse   out  one-cycle strobe for a long press
//   mode         out  current mode, 0 .. NUM_MODES-1
module key_press_ctrl #(
    parameter int unsigned DEBOUNCE  = 500,
    parameter int unsigned LONG      = 2000,
    parameter int unsigned NUM_MODES = 4,
    parameter int unsigned MODE_W    = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              key_in,
    output logic              pressed,
    output logic              short_pulse,
    output logic              long_pulse,
    output logic [MODE_W-1:0] mode
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE);
    localparam int unsigned HOLD_W = $clog2(LONG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_e;

    logic              sync1_q;
    logic              key_s_q;
    logic              key_db_q, key_db_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic [MODE_W-1:0] mode_q, mode_d;

    // Two-stage synchronizer, reset to the released level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            key_s_q <= 1'b1;
        end else begin
            sync1_q <= key_in;
            key_s_q <= sync1_q;
        end
    end

    // Debouncer: accept a new level only after DEBOUNCE consecutive cycles
    // of disagreement; any return to the accepted level restarts the count.
    always_comb begin
        key_db_d = key_db_q;
        db_cnt_d = '0;
        if (key_s_q != key_db_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
                key_db_d = key_s_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // The FSM looks at key_db_d so that it reacts on the same edge that
    // changes the accepted level: long_pulse lands exactly LONG cycles after
    // pressed rises, and short_pulse rises with the edge that clears pressed.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (!key_db_d) begin
                    state_d = PRESS;
                    hold_d  = '0;
                end
            end
            PRESS: begin
                // Long has priority: a press of exactly LONG cycles is long.
                if (hold_q == HOLD_W'(LONG - 1)) begin
                    state_d = HOLD;
                    long_d  = 1'b1;
                    mode_d  = '0;
                end else if (key_db_d) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                    mode_d  = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + 1'b1;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            HOLD: begin
                if (key_db_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_db_q <= 1'b1;
            db_cnt_q <= '0;
            state_q  <= IDLE;
            hold_q   <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            mode_q   <= '0;
        end else begin
            key_db_q <= key_db_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            short_q  <= short_d;
            long_q   <= long_d;
            mode_q   <= mode_d;
        end
    end

    assign pressed     = ~key_db_q;
    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign mode        = mode_q;

endmodule

// File: tb/tb_key_press_ctrl.sv
// tb_key_press_ctrl
//   Directed bench for key_press_ctrl with DEBOUNCE=10, LONG=40, NUM_MODES=4.
//   Stimulus tasks push the expected press event (kind and resulting mode)
//   into a queue; a monitor pops and compares whenever a pulse appears, and
//   also checks long-press latency against the observed rise of pressed.
module tb_key_press_ctrl;

    localparam int unsigned DB  = 10;
    localparam int unsigned LG  = 40;
    localparam int unsigned NM  = 4;
    localparam int unsigned MW  = 2;

    logic          clk;
    logic          rstn;
    logic          key_in;
    logic          pressed;
    logic          short_pulse;
    logic          long_pulse;
    logic [MW-1:0] mode;

    key_press_ctrl #(
        .DEBOUNCE (DB),
        .LONG     (LG),
        .NUM_MODES(NM),
        .MODE_W   (MW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .key_in     (key_in),
        .pressed    (pressed),
        .short_pulse(short_pulse),
        .long_pulse (long_pulse),
        .mode       (mode)
    );

    typedef struct {
        bit is_long;
        int mode;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   mode_m = 0;
    int   cyc    = 0;
    int   rise_cyc = 0;
    logic prev_pressed = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model of one debounced press of n cycles of pressed=1.
    task automatic expect_press(input int n);
        exp_t e;
        if (n >= int'(LG)) begin
            mode_m = 0;
            e.is_long = 1'b1;
        end else begin
            mode_m = (mode_m + 1) % int'(NM);
            e.is_long = 1'b0;
        end
        e.mode = mode_m;
        q.push_back(e);
    endtask

    task automatic press(input int n);
        expect_press(n);
        key_in = 1'b0;
        tick(n);
        key_in = 1'b1;
        tick(60);
    endtask

    // Press of low_n cycles followed by a 15-cycle bouncy release (3-cycle
    // segments); the last low segment ends 12 cycles after low_n.
    task automatic bouncy(input int low_n);
        expect_press(low_n + 12);
        key_in = 1'b0;
        tick(low_n);
        for (int k = 0; k < 5; k++) begin
            key_in = (k % 2 == 0) ? 1'b1 : 1'b0;
            tick(3);
        end
        key_in = 1'b1;
        tick(60);
    endtask

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (pressed && !prev_pressed) rise_cyc = cyc;
        prev_pressed = pressed;
        if (rstn && (short_pulse || long_pulse)) begin
            if (short_pulse && long_pulse)
                check("pulse_exclusive", 1, 0);
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, long_pulse, short_pulse}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_kind_long", int'(long_pulse), int'(e.is_long));
                check("pulse_mode", int'(mode), e.mode);
                if (long_pulse)
                    check("long_latency", cyc - rise_cyc, int'(LG));
            end
        end
    end

    initial begin
        int seen;
        rstn   = 1'b0;
        key_in = 1'b1;
        tick(3);
        check("reset_outputs", int'({pressed, short_pulse, long_pulse, mode}), 0);
        rstn = 1'b1;
        tick(3);
        check("post_reset_outputs", int'({pressed, short_pulse, long_pulse, mode}), 0);

        // Glitch shorter than DEBOUNCE.
        key_in = 1'b0;
        tick(8);
        key_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (pressed) seen = 1;
        end
        check("glitch_pressed", seen, 0);
        check("glitch_mode", int'(mode), 0);

        // Short press of 25 cycles with latency check on pressed.
        expect_press(25);
        key_in = 1'b0;
        tick(11);
        check("press_latency_11", int'(pressed), 0);
        tick(1);
        check("press_latency_12", int'(pressed), 1);
        tick(13);
        key_in = 1'b1;
        tick(60);
        check("short_mode", int'(mode), 1);

        press(20);                      // mode 2
        press(100);                     // long from mode 2 -> 0
        check("long_mode", int'(mode), 0);

        // Wrap: 1, 2, 3, 0.
        for (int i = 0; i < 4; i++) press(15 + 3 * i);
        check("wrap_mode", int'(mode), 0);

        // Boundaries of the long threshold.
        press(int'(LG) - 1);            // short -> 1
        check("boundary_short_mode", int'(mode), 1);
        press(int'(LG));                // long -> 0
        check("boundary_long_mode", int'(mode), 0);

        bouncy(20);                     // 32 cycles: short -> 1
        bouncy(50);                     // long -> 0

        // Asynchronous reset while in HOLD, key still held afterwards.
        expect_press(100);
        key_in = 1'b0;
        tick(70);
        check("hold_pressed", int'(pressed), 1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_outputs", int'({pressed, short_pulse, long_pulse, mode}), 0);
        tick(4);
        mode_m = 0;
        expect_press(30);               // held key seen as a fresh press
        rstn = 1'b1;
        check("rerelease_outputs", int'({pressed, short_pulse, long_pulse, mode}), 0);
        tick(30);
        key_in = 1'b1;
        tick(60);

        seen = 0;
        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        check("queue_drained", q.size(), 0);
        check("final_mode", int'(mode), mode_m);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
